// File: rtl/route_cmd_seq.sv
// route_cmd_seq: FIFO-fed route sequencer executing 2-bit veer/turn opcodes back to back.
// Define ROUTE_ABORT_EN to add the `abort` input (flush queue, return to IDLE).
module route_cmd_seq #(
    parameter int          CMD_W     = 16,
    parameter int          DEPTH     = 4,
    parameter int          NUM_BMP   = 2,
    parameter int          TURN1_CYC = 655360,
    parameter int          TURN2_CYC = 1048576,
    parameter int          DBNC_CYC  = 131072,
    parameter logic [15:0] VEER_MAG  = 16'h340,
    parameter logic [15:0] TURN1_MAG = 16'h1E0,
    parameter logic [15:0] TURN2_MAG = 16'h380
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [CMD_W-1:0]         cmd,
    input  logic                     cmd_vld,
    output logic                     cmd_rdy,
    input  logic                     line_present,
    input  logic [NUM_BMP-1:0]       bmp_n,
`ifdef ROUTE_ABORT_EN
    input  logic                     abort,
`endif
    output logic                     go,
    output logic signed [15:0]       err_opn_lp,
    output logic                     buzz,
    output logic                     busy,
    output logic [$clog2(DEPTH):0]   fifo_cnt
);

    localparam int PTR_W   = $clog2(DEPTH);
    localparam int CNT_W   = PTR_W + 1;
    localparam int TURN_MX = (TURN1_CYC > TURN2_CYC) ? TURN1_CYC : TURN2_CYC;
    localparam int TMR_MX  = (TURN_MX > DBNC_CYC) ? TURN_MX : DBNC_CYC;
    localparam int TMR_W   = $clog2(TMR_MX);

    localparam logic [TMR_W-1:0] TMR_SAT  = '1;
    localparam logic [TMR_W-1:0] T1_END   = TMR_W'(TURN1_CYC - 1);
    localparam logic [TMR_W-1:0] T2_END   = TMR_W'(TURN2_CYC - 1);
    localparam logic [TMR_W-1:0] DB_END   = TMR_W'(DBNC_CYC - 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

    typedef enum logic [2:0] {
        S_IDLE, S_MOVE, S_VEER, S_TURN_A, S_TURN_B, S_AWAIT_LINE, S_COLLISION
    } state_t;

    state_t            state, state_n;
    logic [CMD_W-1:0]  mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr, rd_ptr;
    logic [CNT_W-1:0]  cnt_n;
    logic [CMD_W-1:0]  sreg;
    logic [TMR_W-1:0]  tmr;
    logic              last_r;
    logic              push, pop, retire, tmr_clr, buzz_tgl;
    logic              abort_i, fifo_empty, bump;
    logic [1:0]        op;

`ifdef ROUTE_ABORT_EN
    assign abort_i = abort;
`else
    assign abort_i = 1'b0;
`endif

    assign fifo_empty = (fifo_cnt == '0);
    assign bump       = ~&bmp_n;
    assign op         = sreg[1:0];
    assign push       = cmd_vld && cmd_rdy && !abort_i;
    assign busy       = (state != S_IDLE);

    // NOTE: every variable driven here gets a default first, so no path can infer a latch.
    always_comb begin
        state_n  = state;
        go       = 1'b0;
        pop      = 1'b0;
        retire   = 1'b0;
        tmr_clr  = 1'b0;
        buzz_tgl = 1'b0;
        case (state)
            S_IDLE: if (!fifo_empty && line_present) begin
                pop     = 1'b1;
                go      = 1'b1;
                state_n = S_MOVE;
            end
            S_MOVE: begin
                go = 1'b1;
                if (line_present && bump) begin
                    state_n  = S_COLLISION;
                    go       = 1'b0;
                    tmr_clr  = 1'b1;
                    buzz_tgl = 1'b1;
                end else if (!line_present) begin
                    if (op == 2'b11) begin
                        state_n = S_TURN_A;
                        go      = 1'b0;
                        tmr_clr = 1'b1;
                    end else if (op != 2'b00) begin
                        state_n = S_VEER;
                    end else if (!fifo_empty) begin
                        pop = 1'b1;
                    end else begin
                        state_n = S_IDLE;
                        go      = 1'b0;
                    end
                end
            end
            S_VEER: begin
                go = 1'b1;
                if (line_present) begin
                    retire  = 1'b1;
                    state_n = S_MOVE;
                end
            end
            S_TURN_A: begin
                go = 1'b1;
                if (tmr == T1_END) begin
                    go      = 1'b0;
                    tmr_clr = 1'b1;
                    state_n = S_TURN_B;
                end
            end
            S_TURN_B: begin
                go = 1'b1;
                if (tmr == T2_END) state_n = S_AWAIT_LINE;
            end
            S_AWAIT_LINE: begin
                go = 1'b1;
                if (line_present) begin
                    retire  = 1'b1;
                    state_n = S_MOVE;
                end
            end
            S_COLLISION: begin
                if (&bmp_n) begin
                    state_n = S_MOVE;
                end else if (tmr == DB_END) begin
                    buzz_tgl = 1'b1;
                    tmr_clr  = 1'b1;
                end
            end
            default: state_n = S_IDLE;
        endcase
        if (abort_i) state_n = S_IDLE;
    end

    // A veer steers toward the opcode being executed; last_r adopts it only when it retires.
    always_comb begin
        err_opn_lp = '0;
        case (state)
            S_VEER:   err_opn_lp = sreg[0] ? VEER_MAG : -VEER_MAG;
            S_TURN_A: err_opn_lp = last_r ? -TURN1_MAG : TURN1_MAG;
            S_TURN_B: err_opn_lp = last_r ? TURN2_MAG : -TURN2_MAG;
            default:  err_opn_lp = '0;
        endcase
    end

    always_comb begin
        cnt_n = fifo_cnt;
        if (push && !pop)      cnt_n = fifo_cnt + CNT_W'(1);
        else if (pop && !push) cnt_n = fifo_cnt - CNT_W'(1);
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_IDLE;
        else     state <= state_n;
    end

    // NOTE: the storage array is deliberately not reset; pointers and count define what is valid.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= cmd;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            fifo_cnt <= '0;
            cmd_rdy  <= 1'b1;
        end else if (abort_i) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            fifo_cnt <= '0;
            cmd_rdy  <= 1'b1;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            fifo_cnt <= cnt_n;
            cmd_rdy  <= (cnt_n != CNT_FULL);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sreg   <= '0;
            last_r <= 1'b0;
        end else if (abort_i) begin
            sreg   <= '0;
        end else if (pop) begin
            sreg   <= mem[rd_ptr];
        end else if (retire) begin
            sreg   <= sreg >> 2;
            last_r <= sreg[0];
        end
    end

    // Timer saturates rather than wrapping so long waits can never alias a terminal count.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                 tmr <= '0;
        else if (tmr_clr)        tmr <= '0;
        else if (tmr != TMR_SAT) tmr <= tmr + TMR_W'(1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)                         buzz <= 1'b0;
        else if (state_n != S_COLLISION) buzz <= 1'b0;
        else if (buzz_tgl)               buzz <= ~buzz;
    end

endmodule

// File: tb/tb_route_cmd_seq.sv
// Self-checking bench for route_cmd_seq: queue-based behavioural model plus directed literal checks.
// Exercises the abort input only when ROUTE_ABORT_EN is defined.
`timescale 1ns/1ps
module tb_route_cmd_seq;

    localparam int          CMD_W = 8;
    localparam int          DEPTH = 4;
    localparam int          NUM_BMP = 2;
    localparam int          T1 = 12;
    localparam int          T2 = 20;
    localparam int          DB = 6;
    localparam logic [15:0] VM  = 16'h0340;
    localparam logic [15:0] T1M = 16'h01E0;
    localparam logic [15:0] T2M = 16'h0380;

    logic                   clk = 1'b0;
    logic                   rst;
    logic [CMD_W-1:0]       cmd;
    logic                   cmd_vld, cmd_rdy, line_present;
    logic [NUM_BMP-1:0]     bmp_n;
    logic                   go, buzz, busy;
    logic [15:0]            err_opn_lp;
    logic [$clog2(DEPTH):0] fifo_cnt;
    logic                   bump_any;
    logic                   ab_in;
`ifdef ROUTE_ABORT_EN
    logic                   abort;
    assign ab_in = abort;
`else
    assign ab_in = 1'b0;
`endif
    assign bump_any = ~&bmp_n;

    route_cmd_seq #(
        .CMD_W(CMD_W), .DEPTH(DEPTH), .NUM_BMP(NUM_BMP),
        .TURN1_CYC(T1), .TURN2_CYC(T2), .DBNC_CYC(DB),
        .VEER_MAG(VM), .TURN1_MAG(T1M), .TURN2_MAG(T2M)
    ) dut (
        .clk(clk), .rst(rst), .cmd(cmd), .cmd_vld(cmd_vld), .cmd_rdy(cmd_rdy),
        .line_present(line_present), .bmp_n(bmp_n),
`ifdef ROUTE_ABORT_EN
        .abort(abort),
`endif
        .go(go), .err_opn_lp(err_opn_lp), .buzz(buzz), .busy(busy), .fifo_cnt(fifo_cnt)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            if (n_fail <= 40) $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    typedef enum {M_IDLE, M_MOVE, M_VEER, M_TURN_A, M_TURN_B, M_AWAIT, M_COLL} mmode_t;
    mmode_t md;
    int     fq[$];
    int     ops[$];
    bit     lastr, mbuzz, mrdy;
    int     tcnt;

    function automatic void m_reset();
        fq.delete(); ops.delete();
        md = M_IDLE; lastr = 1'b0; mbuzz = 1'b0; mrdy = 1'b1; tcnt = 0;
    endfunction

    // A word is the list of its opcodes, LSB first, up to the first 00.
    function automatic void m_load();
        int w;
        w = fq.pop_front();
        ops.delete();
        for (int i = 0; i < CMD_W / 2; i++) begin
            int op;
            op = (w >> (2 * i)) & 3;
            if (op == 0) break;
            ops.push_back(op);
        end
    endfunction

    function automatic void m_retire();
        lastr = bit'(ops[0] & 1);
        void'(ops.pop_front());
    endfunction

    function automatic logic [15:0] m_err();
        case (md)
            M_VEER:   return (ops[0] & 1) != 0 ? VM : -VM;
            M_TURN_A: return lastr ? -T1M : T1M;
            M_TURN_B: return lastr ? T2M : -T2M;
            default:  return 16'h0000;
        endcase
    endfunction

    function automatic bit m_go(input bit line, input bit bump);
        case (md)
            M_IDLE:   return fq.size() > 0 && line;
            M_MOVE: begin
                if (line) return !bump;
                if (ops.size() > 0) return ops[0] != 3;
                return fq.size() > 0;
            end
            M_TURN_A: return tcnt != T1 - 1;
            M_COLL:   return 1'b0;
            default:  return 1'b1;
        endcase
    endfunction

    function automatic void m_step(input bit line, input bit bump, input bit vld,
                                   input logic [CMD_W-1:0] word, input bit ab);
        mmode_t nxt;
        bit     pushed, tgl;
        if (ab) begin
            fq.delete(); ops.delete();
            md = M_IDLE; mbuzz = 1'b0; mrdy = 1'b1;
            return;
        end
        pushed = vld && mrdy;
        nxt = md;
        tgl = 1'b0;
        case (md)
            M_IDLE: if (fq.size() > 0 && line) begin m_load(); nxt = M_MOVE; end
            M_MOVE: begin
                if (line && bump) begin nxt = M_COLL; tcnt = 0; tgl = 1'b1; end
                else if (!line) begin
                    if (ops.size() > 0 && ops[0] == 3) begin nxt = M_TURN_A; tcnt = 0; end
                    else if (ops.size() > 0) nxt = M_VEER;
                    else if (fq.size() > 0) m_load();
                    else nxt = M_IDLE;
                end
            end
            M_VEER:   if (line) begin m_retire(); nxt = M_MOVE; end
            M_TURN_A: if (tcnt == T1 - 1) begin tcnt = 0; nxt = M_TURN_B; end else tcnt++;
            M_TURN_B: if (tcnt == T2 - 1) nxt = M_AWAIT; else tcnt++;
            M_AWAIT:  if (line) begin m_retire(); nxt = M_MOVE; end
            M_COLL: begin
                if (!bump) nxt = M_MOVE;
                else if (tcnt == DB - 1) begin tgl = 1'b1; tcnt = 0; end
                else tcnt++;
            end
            default: nxt = M_IDLE;
        endcase
        mbuzz = (nxt == M_COLL) ? (mbuzz ^ tgl) : 1'b0;
        if (pushed) fq.push_back(int'(word));
        mrdy = (fq.size() != DEPTH);
        md = nxt;
    endfunction

    // Single compare process: outputs vs model every cycle, then advance the model.
    always @(negedge clk) begin
        if (rst) m_reset();
        else begin
            check("go",       32'(go),         32'(m_go(line_present, bump_any)));
            check("err",      32'(err_opn_lp), 32'(m_err()));
            check("buzz",     32'(buzz),       32'(mbuzz));
            check("busy",     32'(busy),       32'(md != M_IDLE));
            check("cmd_rdy",  32'(cmd_rdy),    32'(mrdy));
            check("fifo_cnt", 32'(fifo_cnt),   32'(fq.size()));
            m_step(line_present, bump_any, cmd_vld, cmd, ab_in);
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_word(input logic [CMD_W-1:0] w);
        cmd = w; cmd_vld = 1'b1;
        tick();
        cmd_vld = 1'b0;
    endtask

    task automatic chk_reset_vals(input string tag);
        check({tag, "_go"},       32'(go),         32'd0);
        check({tag, "_err"},      32'(err_opn_lp), 32'd0);
        check({tag, "_buzz"},     32'(buzz),       32'd0);
        check({tag, "_busy"},     32'(busy),       32'd0);
        check({tag, "_cmd_rdy"},  32'(cmd_rdy),    32'd1);
        check({tag, "_fifo_cnt"}, 32'(fifo_cnt),   32'd0);
    endtask

    initial begin
        rst = 1'b1; cmd = '0; cmd_vld = 1'b0; line_present = 1'b0; bmp_n = '1;
`ifdef ROUTE_ABORT_EN
        abort = 1'b0;
`endif
        #3;
        chk_reset_vals("rst0");
        #9 rst = 1'b0;
        tick();

        // Two veer-right opcodes in one word, then exhaustion to IDLE.
        line_present = 1'b1;
        push_word(8'h05);
        @(negedge clk);
        check("t1_launch_go", 32'(go), 32'd1);
        check("t1_launch_cnt", 32'(fifo_cnt), 32'd1);
        tick(); tick(); tick();
        line_present = 1'b0; tick();
        @(negedge clk);
        check("t1_veer1_err", 32'(err_opn_lp), 32'h0340);
        check("t1_veer1_go", 32'(go), 32'd1);
        line_present = 1'b1; tick();
        line_present = 1'b0; tick();
        @(negedge clk);
        check("t1_veer2_err", 32'(err_opn_lp), 32'h0340);
        line_present = 1'b1; tick();
        line_present = 1'b0;
        @(negedge clk);
        check("t1_end_go", 32'(go), 32'd0);
        tick();
        @(negedge clk);
        check("t1_idle_busy", 32'(busy), 32'd0);

        // Back-to-back words: right then left, go held across the boundary.
        push_word(8'h01);
        push_word(8'h02);
        @(negedge clk);
        check("t2_cnt2", 32'(fifo_cnt), 32'd2);
        line_present = 1'b1; tick();
        @(negedge clk);
        check("t2_cnt1", 32'(fifo_cnt), 32'd1);
        line_present = 1'b0; tick();
        @(negedge clk);
        check("t2_err_r", 32'(err_opn_lp), 32'h0340);
        line_present = 1'b1; tick();
        line_present = 1'b0;
        @(negedge clk);
        check("t2_boundary_go", 32'(go), 32'd1);
        tick();
        @(negedge clk);
        check("t2_cnt0", 32'(fifo_cnt), 32'd0);
        check("t2_dispatch_go", 32'(go), 32'd1);
        tick();
        @(negedge clk);
        check("t2_err_l", 32'(err_opn_lp), 32'hFCC0);
        line_present = 1'b1; tick();
        line_present = 1'b0; tick();

        // Veer left then turn around.
        line_present = 1'b1;
        push_word(8'h0E);
        tick();
        line_present = 1'b0; tick();
        @(negedge clk);
        check("t3_veer_l", 32'(err_opn_lp), 32'hFCC0);
        line_present = 1'b1; tick();
        line_present = 1'b0;
        @(negedge clk);
        check("t3_turn_go0", 32'(go), 32'd0);
        tick();
        for (int i = 0; i < T1; i++) begin
            @(negedge clk);
            check("t3_ta_err", 32'(err_opn_lp), 32'h01E0);
            check("t3_ta_go", 32'(go), (i != T1 - 1) ? 32'd1 : 32'd0);
            tick();
        end
        for (int i = 0; i < T2; i++) begin
            @(negedge clk);
            check("t3_tb_err", 32'(err_opn_lp), 32'hFC80);
            check("t3_tb_go", 32'(go), 32'd1);
            tick();
        end
        @(negedge clk);
        check("t3_await_err", 32'(err_opn_lp), 32'd0);
        check("t3_await_go", 32'(go), 32'd1);
        line_present = 1'b1; tick();
        line_present = 1'b0; tick();

        // Collision with buzzer toggling, then release.
        line_present = 1'b1;
        push_word(8'h01);
        tick();
        bmp_n = 2'b10;
        @(negedge clk);
        check("t4_hit_go", 32'(go), 32'd0);
        tick();
        for (int i = 0; i < 2 * DB; i++) begin
            @(negedge clk);
            check("t4_buzz", 32'(buzz), ((i / DB) % 2 == 0) ? 32'd1 : 32'd0);
            check("t4_go", 32'(go), 32'd0);
            tick();
        end
        bmp_n = 2'b11; tick();
        @(negedge clk);
        check("t4_rel_buzz", 32'(buzz), 32'd0);
        check("t4_rel_busy", 32'(busy), 32'd1);
        line_present = 1'b0; tick();
        line_present = 1'b1; tick();
        line_present = 1'b0; tick();

        // Overfill the FIFO, then reset in the middle of TURN_B.
        for (int k = 0; k <= DEPTH; k++) begin
            cmd = 8'h03; cmd_vld = 1'b1; tick();
        end
        cmd_vld = 1'b0;
        @(negedge clk);
        check("t5_full_rdy", 32'(cmd_rdy), 32'd0);
        check("t5_full_cnt", 32'(fifo_cnt), 32'(DEPTH));
        line_present = 1'b1; tick();
        line_present = 1'b0; tick();
        repeat (T1 + 5) tick();
        #2 rst = 1'b1;
        #1 chk_reset_vals("t5_rst");
        tick();
        rst = 1'b0;
        tick();

`ifdef ROUTE_ABORT_EN
        // Abort during VEER with three words still queued.
        for (int k = 0; k < 4; k++) push_word(8'h01);
        line_present = 1'b1; tick();
        line_present = 1'b0; tick();
        @(negedge clk);
        check("t6_pre_cnt", 32'(fifo_cnt), 32'd3);
        abort = 1'b1; tick();
        abort = 1'b0;
        @(negedge clk);
        check("t6_busy", 32'(busy), 32'd0);
        check("t6_cnt", 32'(fifo_cnt), 32'd0);
        check("t6_err", 32'(err_opn_lp), 32'd0);
        tick();
`endif

        // Randomized traffic checked by the model.
        for (int c = 0; c < 4000; c++) begin
            if ($urandom_range(0, 4) == 0) line_present = ~line_present;
            if (bmp_n != 2'b11) begin
                if ($urandom_range(0, 7) == 0) bmp_n = 2'b11;
            end else if ($urandom_range(0, 40) == 0) begin
                bmp_n = NUM_BMP'($urandom_range(0, 2));
            end
            cmd_vld = ($urandom_range(0, 2) == 0);
            cmd     = CMD_W'($urandom);
`ifdef ROUTE_ABORT_EN
            abort = ($urandom_range(0, 199) == 0);
`endif
            tick();
        end
        cmd_vld = 1'b0;
        tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        n_fail++;
        $display("FAIL watchdog: simulation did not complete, expected finish before %0t", $time);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
